cart_mapper: RTL and testbench

- Parametrised cartridge bank-switching mapper between the 6502 address bus and the cartridge dprom.
- Replaces the fixed 4K direct mapping (rom address = cpu address[11:0]) with selectable schemes: none, F8, F6, F4, E0 and 3F.
- Includes optional 128-byte Superchip RAM.
- Sits beside the tia and pia; it is clocked by clk_sys and strobed by the same cpu_enable pulse as the pia.

---
 rtl/cart_mapper.sv | 171 +++++++++++++++++
 tb/tb_cart_mapper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_mapper.sv
// Cartridge bank-switching mapper between the 6502 address bus and the cartridge ROM.
// Supports none/F8/F6/F4/E0/3F schemes plus an optional 128-byte Superchip RAM.
module cart_mapper #(
  parameter int ROM_ADDR_BITS = 15,
  parameter bit SUPERCHIP     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [2:0]               mode_i,
  input  logic                     sc_en_i,
  input  logic [12:0]              adr_i,
  input  logic                     we_i,
  input  logic [7:0]               dat_i,
  output logic [ROM_ADDR_BITS-1:0] rom_adr_o,
  output logic                     ram_sel_o,
  output logic [7:0]               dat_o,
  output logic [7:0]               bank_o
);

  localparam int AW   = ROM_ADDR_BITS;
  localparam int BW3F = ROM_ADDR_BITS - 11;

  typedef enum logic [2:0] {
    M_NONE = 3'd0,
    M_F8   = 3'd1,
    M_F6   = 3'd2,
    M_F4   = 3'd3,
    M_E0   = 3'd4,
    M_3F   = 3'd5
  } mode_t;

  // Strobe semantics: enable_i qualifies adr_i/we_i/dat_i for exactly one
  // clk_i cycle; there is no backpressure, every strobed access is taken.

  logic [2:0]      r_mode;
  logic [2:0]      r_bank;
  logic [2:0]      r_slice0;
  logic [2:0]      r_slice1;
  logic [2:0]      r_slice2;
  logic [BW3F-1:0] r_bank3f;

  mode_t           w_mode;
  logic            w_hs_hit;
  logic [2:0]      w_hs_bank;
  logic [2:0]      w_e0_ld;
  logic            w_3f_ld;
  logic            w_mode_chg;
  logic [2:0]      w_slice;
  logic            w_sc_act;
  logic            w_sc_wr;
  logic            w_sc_rd;

  function automatic logic [2:0] init_bank(input mode_t m);
    case (m)
      M_F8:    init_bank = 3'd1;
      M_F6:    init_bank = 3'd3;
      M_F4:    init_bank = 3'd7;
      default: init_bank = 3'd0;
    endcase
  endfunction

  assign w_mode     = (mode_i > 3'd5) ? M_NONE : mode_t'(mode_i);
  assign w_mode_chg = (mode_i != r_mode);

  always_comb begin
    w_hs_hit  = 1'b0;
    w_hs_bank = 3'd0;
    w_e0_ld   = 3'b000;
    if (enable_i && adr_i[12]) begin
      case (w_mode)
        M_F8: begin
          w_hs_hit  = (adr_i[11:0] == 12'hFF8) || (adr_i[11:0] == 12'hFF9);
          w_hs_bank = 3'(adr_i[11:0] - 12'hFF8);
        end
        M_F6: begin
          w_hs_hit  = (adr_i[11:0] >= 12'hFF6) && (adr_i[11:0] <= 12'hFF9);
          w_hs_bank = 3'(adr_i[11:0] - 12'hFF6);
        end
        M_F4: begin
          w_hs_hit  = (adr_i[11:0] >= 12'hFF4) && (adr_i[11:0] <= 12'hFFB);
          w_hs_bank = 3'(adr_i[11:0] - 12'hFF4);
        end
        M_E0: begin
          w_e0_ld[0] = (adr_i[11:4] == 8'hFE) && !adr_i[3];
          w_e0_ld[1] = (adr_i[11:4] == 8'hFE) &&  adr_i[3];
          w_e0_ld[2] = (adr_i[11:3] == 9'h1FE);
        end
        default: ;
      endcase
    end
  end

  // 3F bank writes land in TIA space, so they are deliberately not gated by adr_i[12]=1.
  assign w_3f_ld = enable_i && we_i && !adr_i[12] && (adr_i[7:6] == 2'b00) && (w_mode == M_3F);

  always_ff @(posedge clk_i) begin
    r_mode <= mode_i;
    if (rst_i || w_mode_chg) begin
      r_bank   <= init_bank(w_mode);
      r_slice0 <= 3'd0;
      r_slice1 <= 3'd0;
      r_slice2 <= 3'd0;
      r_bank3f <= '0;
    end else begin
      if (w_hs_hit)   r_bank   <= w_hs_bank;
      if (w_e0_ld[0]) r_slice0 <= adr_i[2:0];
      if (w_e0_ld[1]) r_slice1 <= adr_i[2:0];
      if (w_e0_ld[2]) r_slice2 <= adr_i[2:0];
      if (w_3f_ld)    r_bank3f <= dat_i[BW3F-1:0];
    end
  end

  always_comb begin
    case (adr_i[11:10])
      2'd0:    w_slice = r_slice0;
      2'd1:    w_slice = r_slice1;
      2'd2:    w_slice = r_slice2;
      default: w_slice = 3'd7;
    endcase
  end

  always_comb begin
    rom_adr_o = AW'(adr_i[11:0]);
    bank_o    = 8'd0;
    case (w_mode)
      M_F8, M_F6, M_F4: begin
        rom_adr_o = AW'({r_bank, adr_i[11:0]});
        bank_o    = 8'(r_bank);
      end
      M_E0: begin
        rom_adr_o = AW'({w_slice, adr_i[9:0]});
        bank_o    = 8'(r_slice0);
      end
      M_3F: begin
        // The upper 2K window is pinned to the last 2K of the ROM.
        rom_adr_o = adr_i[11] ? {{BW3F{1'b1}}, adr_i[10:0]} : {r_bank3f, adr_i[10:0]};
        bank_o    = 8'(r_bank3f);
      end
      default: ;
    endcase
  end

  assign w_sc_act = SUPERCHIP && sc_en_i && (w_mode inside {M_F8, M_F6, M_F4});
  assign w_sc_wr  = w_sc_act && enable_i && we_i && adr_i[12] && (adr_i[11:7] == 5'b00000);
  assign w_sc_rd  = w_sc_act && adr_i[12] && (adr_i[11:7] == 5'b00001);

  generate
    if (SUPERCHIP) begin : g_sc
      logic [7:0] r_ram [128];
      logic [7:0] r_dat;

      // RAM contents deliberately survive reset.
      always_ff @(posedge clk_i) begin
        if (w_sc_wr) r_ram[adr_i[6:0]] <= dat_i;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i)        r_dat <= 8'd0;
        else if (w_sc_rd) r_dat <= r_ram[adr_i[6:0]];
      end

      assign ram_sel_o = w_sc_rd;
      assign dat_o     = r_dat;
    end else begin : g_no_sc
      assign ram_sel_o = 1'b0;
      assign dat_o     = 8'd0;
    end
  endgenerate

endmodule

// File: tb/tb_cart_mapper.sv
// Self-checking bench for cart_mapper: expectations queued per driven cycle,
// compared at the falling edge of that cycle.
module tb_cart_mapper;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  mode_i = 3'd1;
  logic        sc_en_i = 1'b0;
  logic [12:0] adr_i = '0;
  logic        we_i = 1'b0;
  logic [7:0]  dat_i = '0;
  logic [14:0] rom_adr_o;
  logic        ram_sel_o;
  logic [7:0]  dat_o;
  logic [7:0]  bank_o;

  logic        rst_nxt = 1'b1;
  logic [2:0]  mode_nxt = 3'd1;
  logic        sc_nxt = 1'b0;
  string       step = "reset";

  logic [15:0] exp_q[$];
  logic [1:0]  kind_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [1:0] K_ROM = 2'd0, K_BANK = 2'd1, K_SEL = 2'd2, K_DAT = 2'd3;

  always #5 clk = ~clk;

  cart_mapper #(.ROM_ADDR_BITS(15), .SUPERCHIP(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .sc_en_i(sc_en_i), .adr_i(adr_i), .we_i(we_i), .dat_i(dat_i),
    .rom_adr_o(rom_adr_o), .ram_sel_o(ram_sel_o), .dat_o(dat_o), .bank_o(bank_o)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", step, tag, got, exp);
    end
  endtask

  task automatic expect_v(input logic [1:0] kind, input logic [15:0] v);
    kind_q.push_back(kind);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    logic [1:0]  k;
    logic [15:0] e;
    while (exp_q.size() > 0) begin
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      case (k)
        K_ROM:   check("rom_adr", 16'(rom_adr_o), e);
        K_BANK:  check("bank", 16'(bank_o), e);
        K_SEL:   check("ram_sel", 16'(ram_sel_o), e);
        default: check("dat", 16'(dat_o), e);
      endcase
    end
  endtask

  task automatic drive(input logic en, input logic [12:0] a, input logic w, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst_i    = rst_nxt;
    mode_i   = mode_nxt;
    sc_en_i  = sc_nxt;
    enable_i = en;
    adr_i    = a;
    we_i     = w;
    dat_i    = d;
    @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    rst_nxt = 1'b0;

    step = "f8";
    expect_v(K_ROM, 16'h1FFC); expect_v(K_BANK, 16'd1); expect_v(K_DAT, 16'h00);
    drive(1'b1, 13'h1FFC, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1FF8);
    drive(1'b1, 13'h1FF8, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0234); expect_v(K_BANK, 16'd0);
    drive(1'b1, 13'h1234, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0FF9);
    drive(1'b1, 13'h1FF9, 1'b1, 8'h00);
    expect_v(K_ROM, 16'h1234); expect_v(K_BANK, 16'd1);
    drive(1'b1, 13'h1234, 1'b0, 8'h00);

    step = "f4";
    mode_nxt = 3'd3;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h7500); expect_v(K_BANK, 16'd7);
    drive(1'b1, 13'h1500, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h7FF6);
    drive(1'b1, 13'h1FF6, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h2500); expect_v(K_BANK, 16'd2);
    drive(1'b1, 13'h1500, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h2FFB);
    drive(1'b0, 13'h1FFB, 1'b1, 8'h00);
    expect_v(K_ROM, 16'h2500); expect_v(K_BANK, 16'd2);
    drive(1'b1, 13'h1500, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h2FFB);
    drive(1'b1, 13'h1FFB, 1'b1, 8'h00);
    expect_v(K_ROM, 16'h7500); expect_v(K_BANK, 16'd7);
    drive(1'b1, 13'h1500, 1'b0, 8'h00);

    step = "e0";
    mode_nxt = 3'd4;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1C10); expect_v(K_BANK, 16'd0);
    drive(1'b1, 13'h1C10, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0000);
    drive(1'b1, 13'h1000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1FE5);
    drive(1'b1, 13'h1FE5, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1FEA);
    drive(1'b1, 13'h1FEA, 1'b1, 8'h00);
    expect_v(K_ROM, 16'h1FF3);
    drive(1'b1, 13'h1FF3, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1400); expect_v(K_BANK, 16'd5);
    drive(1'b1, 13'h1000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0800);
    drive(1'b1, 13'h1400, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0C00);
    drive(1'b1, 13'h1800, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1C10);
    drive(1'b1, 13'h1C10, 1'b0, 8'h00);

    step = "3f";
    mode_nxt = 3'd5;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0100); expect_v(K_BANK, 16'd0);
    drive(1'b1, 13'h1100, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h003F);
    drive(1'b1, 13'h003F, 1'b1, 8'h09);
    expect_v(K_ROM, 16'h4900); expect_v(K_BANK, 16'd9);
    drive(1'b1, 13'h1100, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h7900);
    drive(1'b1, 13'h1900, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h4840);
    drive(1'b1, 13'h0040, 1'b1, 8'h02);
    expect_v(K_ROM, 16'h4900); expect_v(K_BANK, 16'd9);
    drive(1'b1, 13'h1100, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h4800);
    drive(1'b1, 13'h1000, 1'b1, 8'h03);
    expect_v(K_ROM, 16'h4900); expect_v(K_BANK, 16'd9);
    drive(1'b1, 13'h1100, 1'b0, 8'h00);

    step = "superchip";
    mode_nxt = 3'd2;
    sc_nxt = 1'b1;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h3005); expect_v(K_SEL, 16'd0); expect_v(K_BANK, 16'd3);
    drive(1'b1, 13'h1005, 1'b1, 8'hA5);
    expect_v(K_SEL, 16'd1);
    drive(1'b1, 13'h1085, 1'b0, 8'h00);
    expect_v(K_DAT, 16'hA5); expect_v(K_SEL, 16'd0); expect_v(K_ROM, 16'h3005);
    drive(1'b1, 13'h1005, 1'b0, 8'h00);
    expect_v(K_SEL, 16'd0);
    drive(1'b1, 13'h107F, 1'b1, 8'h3C);
    expect_v(K_SEL, 16'd1);
    drive(1'b1, 13'h10FF, 1'b0, 8'h00);
    expect_v(K_DAT, 16'h3C);
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    sc_nxt = 1'b0;
    expect_v(K_SEL, 16'd0); expect_v(K_ROM, 16'h3085);
    drive(1'b1, 13'h1085, 1'b0, 8'h00);
    sc_nxt = 1'b1;

    step = "mode_chg";
    expect_v(K_ROM, 16'h3FF6);
    drive(1'b1, 13'h1FF6, 1'b0, 8'h00);
    expect_v(K_BANK, 16'd0);
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    mode_nxt = 3'd1;
    expect_v(K_ROM, 16'h0FF8);
    drive(1'b1, 13'h1FF8, 1'b0, 8'h00);
    expect_v(K_BANK, 16'd1); expect_v(K_ROM, 16'h1234);
    drive(1'b1, 13'h1234, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h1FF8);
    drive(1'b1, 13'h1FF8, 1'b0, 8'h00);
    expect_v(K_BANK, 16'd0); expect_v(K_ROM, 16'h0234); expect_v(K_DAT, 16'h3C);
    drive(1'b1, 13'h1234, 1'b0, 8'h00);

    step = "mid_reset";
    rst_nxt = 1'b1;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    rst_nxt = 1'b0;
    expect_v(K_BANK, 16'd1); expect_v(K_DAT, 16'h00); expect_v(K_ROM, 16'h1234);
    drive(1'b1, 13'h1234, 1'b0, 8'h00);

    step = "mode6";
    mode_nxt = 3'd6;
    drive(1'b0, 13'h0000, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0ABC); expect_v(K_BANK, 16'd0);
    drive(1'b1, 13'h1ABC, 1'b0, 8'h00);
    expect_v(K_ROM, 16'h0085); expect_v(K_SEL, 16'd0);
    drive(1'b1, 13'h1085, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
